// File: rtl/phase_array_driver_if.sv
`default_nettype none
// ============================================================================
// Module   : phase_array_driver_if
// Purpose  : Serial host link and register-chain outputs of the phase driver.
// Revision : 1.0 - initial release
// ============================================================================
interface phase_array_driver_if #(
    parameter int LANES = 8
);
    logic             sClk;
    logic             serialIn;
    logic             sCs;
    logic             latch;
    logic             clock;
    logic [LANES-1:0] data;

    modport master (
        output sClk, serialIn, sCs,
        input  latch, clock, data
    );

    modport slave (
        input  sClk, serialIn, sCs,
        output latch, clock, data
    );
endinterface
`default_nettype wire

// File: rtl/phase_array_driver.sv
`default_nettype none
// ============================================================================
// Module   : phase_array_driver
// Purpose  : Per-channel square-wave phase generator fed by a serial host link,
//            streamed out over LANES shift-register chains. Optional mute code
//            enabled by defining CHANNEL_MUTE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module phase_array_driver #(
    parameter int NCH    = 64,
    parameter int PW     = 11,
    parameter int PERIOD = 1000,
    parameter int LANES  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    phase_array_driver_if.slave  bus
);
    localparam int B   = NCH / LANES;
    localparam int IW  = $clog2(NCH);
    localparam int F   = 1 + IW + PW;
    localparam int BCW = $clog2(F + 1);
    localparam int KW  = (B > 1) ? $clog2(B) : 1;
    localparam int CW  = $clog2(PERIOD);

    localparam logic [BCW-1:0] FLEN   = BCW'(F);
    localparam logic [PW:0]    PLIM   = (PW+1)'(PERIOD);
    localparam logic [PW+1:0]  PER_W  = (PW+2)'(PERIOD);
    localparam logic [PW+1:0]  HALF_W = (PW+2)'(PERIOD / 2);
    localparam logic [CW-1:0]  CLAST  = CW'(PERIOD - 1);

    localparam logic [1:0] S_LOAD  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_LATCH = 2'd2;

    // ------------------------------------------------------------------
    // Input synchronisers and frame assembly
    // ------------------------------------------------------------------
    logic [2:0]     sclk_q;
    logic [1:0]     sdat_q;
    logic [1:0]     scs_q;
    logic [BCW-1:0] bitcnt_q, bitcnt_d;
    logic [F-2:0]   shreg_q, shreg_d;
    logic           w_capture;
    logic           w_frame_done;
    logic [F-1:0]   w_frame;
    logic           w_commit;
    logic [IW-1:0]  w_idx;
    logic [PW-1:0]  w_phase;
    logic           w_phase_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            sdat_q <= '0;
            scs_q  <= '0;
        end else begin
            sclk_q <= {sclk_q[1:0], bus.sClk};
            sdat_q <= {sdat_q[0], bus.serialIn};
            scs_q  <= {scs_q[0], bus.sCs};
        end
    end

    assign w_capture = sclk_q[1] & ~sclk_q[2] & ~scs_q[1];

    always_comb begin
        bitcnt_d     = bitcnt_q;
        shreg_d      = shreg_q;
        w_frame_done = 1'b0;
        if (scs_q[1]) begin
            bitcnt_d = '0;
        end else if (w_capture && (bitcnt_q < FLEN)) begin
            shreg_d      = {shreg_q[F-3:0], sdat_q[1]};
            bitcnt_d     = bitcnt_q + 1'b1;
            w_frame_done = (bitcnt_q == FLEN - 1'b1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bitcnt_q <= '0;
            shreg_q  <= '0;
        end else begin
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
        end
    end

    // The final bit is folded in directly so the table write needs no extra cycle.
    assign w_frame  = {shreg_q, sdat_q[1]};
    assign w_commit = w_frame[F-1];
    assign w_idx    = w_frame[F-2:PW];
    assign w_phase  = w_frame[PW-1:0];

`ifdef CHANNEL_MUTE_EN
    assign w_phase_ok = ({1'b0, w_phase} < PLIM) || (w_phase == {PW{1'b1}});
`else
    assign w_phase_ok = ({1'b0, w_phase} < PLIM);
`endif

    // ------------------------------------------------------------------
    // Carrier counter, shadow/active tables, commit
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_q, cnt_d;
    logic          w_wrap;
    logic          pending_q, pending_d;
    logic [PW-1:0] shadow_q [NCH];
    logic [PW-1:0] active_q [NCH];

    assign w_wrap    = (cnt_q == CLAST);
    assign cnt_d     = w_wrap ? '0 : cnt_q + 1'b1;
    assign pending_d = (w_frame_done && w_commit) ? 1'b1 :
                       (w_wrap ? 1'b0 : pending_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            if (w_frame_done && w_phase_ok)
                shadow_q[w_idx] <= w_phase;
            if (w_wrap && pending_q)
                active_q <= shadow_q;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel square wave
    // ------------------------------------------------------------------
    logic [NCH-1:0] w_chan;
    logic [NCH-1:0] chan_q;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        logic [PW+1:0] w_sum;
        logic [PW+1:0] w_mod;
        logic          w_mute;
        assign w_sum = (PW+2)'(cnt_q) + PER_W - (PW+2)'(active_q[gi]);
        assign w_mod = (w_sum >= PER_W) ? (w_sum - PER_W) : w_sum;
`ifdef CHANNEL_MUTE_EN
        assign w_mute = (active_q[gi] == {PW{1'b1}});
`else
        assign w_mute = 1'b0;
`endif
        assign w_chan[gi] = ~w_mute & (w_mod < HALF_W);
    end

    // Free-running from the (reset) tables so the first scan after reset is valid.
    always_ff @(posedge clk) begin
        chan_q <= w_chan;
    end

    // ------------------------------------------------------------------
    // Register-chain serializer; outputs are registered for the state entered
    // ------------------------------------------------------------------
    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic             half_q, half_d;
    logic [NCH-1:0]   snap_q, snap_d;
    logic             latch_q, latch_d;
    logic             clock_q, clock_d;
    logic [LANES-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        half_d  = half_q;
        snap_d  = snap_q;
        latch_d = 1'b0;
        clock_d = 1'b0;
        data_d  = data_q;
        case (state_q)
            S_LOAD: begin
                snap_d  = chan_q;
                state_d = S_SHIFT;
                k_d     = KW'(B - 1);
                half_d  = 1'b0;
                for (int l = 0; l < LANES; l++)
                    data_d[l] = chan_q[IW'(l*B + B - 1)];
            end
            S_SHIFT: begin
                if (!half_q) begin
                    half_d  = 1'b1;
                    clock_d = 1'b1;
                end else if (k_q == '0) begin
                    state_d = S_LATCH;
                    latch_d = 1'b1;
                end else begin
                    k_d    = k_q - 1'b1;
                    half_d = 1'b0;
                    for (int l = 0; l < LANES; l++)
                        data_d[l] = snap_q[IW'(l*B) + IW'(k_q) - IW'(1)];
                end
            end
            S_LATCH: state_d = S_LOAD;
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            k_q     <= '0;
            half_q  <= 1'b0;
            snap_q  <= '0;
            latch_q <= 1'b0;
            clock_q <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            half_q  <= half_d;
            snap_q  <= snap_d;
            latch_q <= latch_d;
            clock_q <= clock_d;
            data_q  <= data_d;
        end
    end

    assign bus.latch = latch_q;
    assign bus.clock = clock_q;
    assign bus.data  = data_q;

endmodule
`default_nettype wire

// File: tb/tb_phase_array_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_array_driver
// Purpose  : Directed self-checking bench for phase_array_driver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_array_driver;
    localparam int NCH    = 64;
    localparam int PW     = 11;
    localparam int PERIOD = 1000;
    localparam int LANES  = 8;
    localparam int B      = NCH / LANES;
    localparam int IW     = 6;
    localparam int F      = 1 + IW + PW;
`ifdef CHANNEL_MUTE_EN
    localparam bit MUTE = 1'b1;
`else
    localparam bit MUTE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    phase_array_driver_if #(.LANES(LANES)) bus ();

    phase_array_driver #(
        .NCH(NCH), .PW(PW), .PERIOD(PERIOD), .LANES(LANES)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;

    always @(posedge clk) ncyc <= rst ? 0 : ncyc + 1;

    // Expected-value model: shadow/active tables and the pending commit.
    int shadow_m [NCH];
    int active_m [NCH];
    bit pending_m;
    int sw_n;

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            shadow_m[i] = 0;
            active_m[i] = 0;
        end
        pending_m = 1'b0;
        sw_n      = 0;
    endtask

    task automatic model_sync(input int s);
        if (pending_m && s >= sw_n) begin
            active_m  = shadow_m;
            pending_m = 1'b0;
        end
    endtask

    function automatic logic [NCH-1:0] exp_img(input int s);
        logic [NCH-1:0] r;
        int c;
        c = (s < 0) ? 0 : s % PERIOD;
        for (int i = 0; i < NCH; i++) begin
            if (MUTE && active_m[i] == 2047) r[i] = 1'b0;
            else r[i] = (((c + PERIOD - active_m[i]) % PERIOD) < PERIOD / 2);
        end
        return r;
    endfunction

    task automatic send_bits(input logic [F-1:0] w, input int nb);
        bus.sCs = 1'b0;
        repeat (3) @(negedge clk);
        for (int b = F - 1; b >= F - nb; b--) begin
            bus.serialIn = w[b];
            bus.sClk     = 1'b0;
            repeat (3) @(negedge clk);
            bus.sClk = 1'b1;
            repeat (3) @(negedge clk);
        end
        bus.sClk = 1'b0;
        repeat (3) @(negedge clk);
        bus.sCs = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic send_frame(input bit cm, input int idx, input int ph);
        logic [F-1:0] w;
        model_sync(ncyc);
        w = {cm, IW'(idx), PW'(ph)};
        send_bits(w, F);
        if (ph < PERIOD || (MUTE && ph == 2047)) shadow_m[idx] = ph;
        if (cm) begin
            pending_m = 1'b1;
            sw_n      = (ncyc / PERIOD + 1) * PERIOD;
        end
    endtask

    task automatic wait_cnt(input int target);
        int n;
        n = 0;
        while ((ncyc % PERIOD) != target && n < 3000) begin
            @(negedge clk);
            n++;
        end
    endtask

    // mode 0: just after a latch cycle; 1: search for latch; 2: in LOAD after reset.
    task automatic grab(input int mode, output logic [NCH-1:0] img,
                        output int s, output bit ok);
        logic [LANES-1:0] d;
        int n;
        ok  = 1'b1;
        img = '0;
        s   = 0;
        if (mode == 1) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (bus.latch !== 1'b1 && n < 60);
            if (bus.latch !== 1'b1) ok = 1'b0;
        end
        if (mode != 2) begin
            @(negedge clk);
            if (bus.latch !== 1'b0 || bus.clock !== 1'b0) ok = 1'b0;
        end
        for (int k = B - 1; k >= 0; k--) begin
            @(negedge clk);
            if (k == B - 1) s = ncyc - 2;
            if (bus.clock !== 1'b0 || bus.latch !== 1'b0) ok = 1'b0;
            d = bus.data;
            for (int l = 0; l < LANES; l++) img[l*B + k] = d[l];
            @(negedge clk);
            if (bus.clock !== 1'b1 || bus.latch !== 1'b0 || bus.data !== d) ok = 1'b0;
        end
        @(negedge clk);
        if (bus.latch !== 1'b1 || bus.clock !== 1'b0) ok = 1'b0;
    endtask

    task automatic test_reset();
        logic [NCH-1:0] img;
        int s, s_prev;
        bit ok;
        rst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if ({bus.latch, bus.clock, bus.data} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 0", {bus.latch, bus.clock, bus.data});
        end
        rst = 1'b0;
        model_reset();
        grab(2, img, s, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL first_scan_framing: got bad LOAD/shift/latch sequence want 8 clocks then latch");
        end
        checks++;
        if (img !== {NCH{1'b1}}) begin
            errors++;
            $display("FAIL first_scan_data: got %h want all ones", img);
        end
        for (int n = 0; n < 3; n++) begin
            s_prev = s;
            grab(0, img, s, ok);
            checks++;
            if (!ok || (s - s_prev) != 2*B + 2) begin
                errors++;
                $display("FAIL scan_repeat %0d: got ok=%0d spacing=%0d want ok=1 spacing=%0d",
                         n, ok, s - s_prev, 2*B + 2);
            end
            checks++;
            if (img !== {NCH{1'b1}}) begin
                errors++;
                $display("FAIL scan_repeat_data %0d: got %h want all ones", n, img);
            end
        end
    endtask

    task automatic test_commit_wrap();
        logic [NCH-1:0] img;
        int s, c;
        bit ok;
        wait_cnt(100);
        send_frame(1'b0, 5, 250);
        send_frame(1'b1, 0, 0);
        for (int n = 0; n < 100; n++) begin
            grab(n == 0 ? 1 : 0, img, s, ok);
            model_sync(s);
            c = s % PERIOD;
            checks++;
            if (!ok || img !== exp_img(s)) begin
                errors++;
                $display("FAIL commit_scan %0d cnt=%0d: got ok=%0d %h want %h", n, c, ok, img, exp_img(s));
            end
            checks++;
            if (img[5] !== ((s >= sw_n) ? (c >= 250 && c <= 749) : (c < 500))) begin
                errors++;
                $display("FAIL commit_ch5 cnt=%0d: got %b want %b", c, img[5],
                         (s >= sw_n) ? (c >= 250 && c <= 749) : (c < 500));
            end
            checks++;
            if (img[0] !== (c < 500)) begin
                errors++;
                $display("FAIL commit_ch0 cnt=%0d: got %b want %b", c, img[0], c < 500);
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [NCH-1:0] img;
        int s, c;
        bit ok;
        wait_cnt(100);
        send_frame(1'b1, 9, 1500);
        for (int n = 0; n < 70; n++) begin
            grab(n == 0 ? 1 : 0, img, s, ok);
            model_sync(s);
            c = s % PERIOD;
            checks++;
            if (!ok || img !== exp_img(s)) begin
                errors++;
                $display("FAIL range_scan %0d cnt=%0d: got ok=%0d %h want %h", n, c, ok, img, exp_img(s));
            end
            checks++;
            if (img[9] !== (c < 500)) begin
                errors++;
                $display("FAIL range_ch9 cnt=%0d: got %b want %b", c, img[9], c < 500);
            end
        end
    endtask

    task automatic test_abort();
        logic [NCH-1:0] img;
        int s, c;
        bit ok;
        wait_cnt(100);
        model_sync(ncyc);
        send_bits({1'b1, 6'd7, 11'd100}, 10);
        send_frame(1'b1, 3, 500);
        for (int n = 0; n < 100; n++) begin
            grab(n == 0 ? 1 : 0, img, s, ok);
            model_sync(s);
            c = s % PERIOD;
            checks++;
            if (!ok || img !== exp_img(s)) begin
                errors++;
                $display("FAIL abort_scan %0d cnt=%0d: got ok=%0d %h want %h", n, c, ok, img, exp_img(s));
            end
            checks++;
            if (img[3] !== ((s >= sw_n) ? (c >= 500) : (c < 500)) || img[7] !== (c < 500)) begin
                errors++;
                $display("FAIL abort_ch3_ch7 cnt=%0d: got %b%b want %b%b", c, img[3], img[7],
                         (s >= sw_n) ? (c >= 500) : (c < 500), c < 500);
            end
        end
    endtask

    task automatic test_mute();
        logic [NCH-1:0] img;
        int s, c;
        bit ok;
        wait_cnt(100);
        send_frame(1'b1, 63, 2047);
        for (int n = 0; n < 100; n++) begin
            grab(n == 0 ? 1 : 0, img, s, ok);
            model_sync(s);
            c = s % PERIOD;
            checks++;
            if (!ok || img !== exp_img(s)) begin
                errors++;
                $display("FAIL mute_scan %0d cnt=%0d: got ok=%0d %h want %h", n, c, ok, img, exp_img(s));
            end
            if (s >= sw_n) begin
                checks++;
                if (img[63] !== (MUTE ? 1'b0 : (c < 500))) begin
                    errors++;
                    $display("FAIL mute_ch63 cnt=%0d: got %b want %b", c, img[63], MUTE ? 1'b0 : (c < 500));
                end
            end
        end
    endtask

    task automatic test_reset_midscan();
        logic [NCH-1:0] img;
        int s, n;
        bit ok;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.latch !== 1'b1 && n < 60);
        checks++;
        if (bus.latch !== 1'b1) begin
            errors++;
            $display("FAIL midscan_sync: got latch=%b want 1 within 60 cycles", bus.latch);
        end
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.latch, bus.clock, bus.data} !== 10'd0) begin
            errors++;
            $display("FAIL midscan_reset_outputs: got %b want 0", {bus.latch, bus.clock, bus.data});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        grab(2, img, s, ok);
        checks++;
        if (!ok || img !== {NCH{1'b1}}) begin
            errors++;
            $display("FAIL midscan_restart: got ok=%0d %h want ok=1 all ones", ok, img);
        end
        for (int k = 0; k < 30; k++) begin
            grab(0, img, s, ok);
            checks++;
            if (!ok || img !== exp_img(s)) begin
                errors++;
                $display("FAIL midscan_scan %0d: got ok=%0d %h want %h", k, ok, img, exp_img(s));
            end
        end
    endtask

    initial begin
        bus.sClk     = 1'b0;
        bus.serialIn = 1'b0;
        bus.sCs      = 1'b1;
        model_reset();
        test_reset();
        test_commit_wrap();
        test_out_of_range();
        test_abort();
        test_mute();
        test_reset_midscan();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/phase_array_driver.md
PHASE_ARRAY_DRIVER -- requirements
Module: phase_array_driver

Interface
REQ-001 SHALL have parameter NCH, default 64: number of output channels, a power of two, at least 2.
REQ-002 SHALL have parameter PW, default 11: phase word width in bits.
REQ-003 SHALL have parameter PERIOD, default 1000: carrier period in clk cycles, even, at most 2^PW-1.
REQ-004 SHALL have parameter LANES, default 8: parallel data lanes; NCH/LANES (B) is an integer, at least 1.
REQ-005 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port sClk, input, 1: serial clock, asynchronous to clk, sampled.
REQ-008 SHALL have port serialIn, input, 1: serial data, MSB first, valid at sClk rising edge.
REQ-009 SHALL have port sCs, input, 1: frame select, active-low.
REQ-010 SHALL have port latch, output, 1: register-chain latch strobe.
REQ-011 SHALL have port clock, output, 1: register-chain shift clock.
REQ-012 SHALL have port data, output, LANES: one serial bit per lane.

Function
REQ-013 SHALL pass sClk, serialIn and sCs each through a 2-flop synchroniser; a bit is captured when synchronised sClk goes 0->1 while synchronised sCs=0.
REQ-014 SHALL define frame = F = 1+log2(NCH)+PW bits: commit flag (MSB), channel index, phase; sCs=1 clears the bit counter and discards any partial frame.
REQ-015 SHALL write phase into the shadow table entry for the index no later than 4 clk cycles after the final sClk rising edge at the pin; bits beyond F before sCs rises are ignored.
REQ-016 SHALL drop (no shadow write) a frame whose phase >= PERIOD; its commit flag still applies.
REQ-017 SHALL set commit_pending when a frame with commit flag=1 completes.
REQ-018 SHALL run counter cnt 0..PERIOD-1, wrapping to 0.
REQ-019 SHALL, on the cycle cnt wraps, copy the full shadow table to the active table if commit_pending (as registered before that cycle) is 1, then clear it; a request registered on the wrap cycle waits for the next wrap.
REQ-020 SHALL drive internal chan[i] = 1 iff ((cnt+PERIOD-active[i]) mod PERIOD) < PERIOD/2, registered, 1-cycle latency.
REQ-021 SHALL run serializer FSM LOAD -> SHIFT -> LATCH -> LOAD continuously.
REQ-022 LOAD (1 cycle): snapshot chan; clock=0, latch=0.
REQ-023 SHIFT (2B cycles): per bit, cycle 1 drives data[l]=snapshot[l*B+k] for k=B-1 down to 0 with clock=0, cycle 2 holds data with clock=1.
REQ-024 LATCH (1 cycle): latch=1, clock=0, data held; scan length 2B+2 cycles.

Reset
REQ-025 SHALL, while rst=1, clear cnt, shadow and active tables, commit_pending, bit counter, synchronisers; FSM to LOAD; latch=0, clock=0, data=0 on the next edge.
REQ-026 SHALL, on reset mid-frame or mid-scan, discard the frame/scan; first scan restarts from LOAD on the cycle after rst falls.

Configuration
REQ-027 SHALL, with CHANNEL_MUTE_EN defined, accept phase 2^PW-1 as a mute code: stored, and chan[i]=0 permanently while active.
REQ-028 SHALL, without CHANNEL_MUTE_EN, treat 2^PW-1 as any other value >= PERIOD (dropped per REQ-016).

Verification
REQ-029 Reset release, all phases 0 -> first scan: 8 shift clocks of data=8'hFF, then latch pulse; scan repeats every 18 cycles.
REQ-030 Frame {0,6'd5,11'd250} then {1,6'd0,11'd0} -> ch5 (lane 0, bit 5) unchanged until next wrap, then high for cnt 250..749; ch0 unchanged.
REQ-031 Frame {1,6'd9,11'd1500} -> shadow unchanged, commit applied at next wrap, all outputs unchanged.
REQ-032 sCs raised after 10 bits, then full frame {1,6'd3,11'd500} -> only ch3 updated, high for cnt 500..999.
REQ-033 rst pulse during SHIFT -> latch/clock/data 0 next edge, LOAD the cycle after rst falls, tables zero.
REQ-034 CHANNEL_MUTE_EN, frame {1,6'd63,11'd2047} -> after wrap ch63 (lane 7, bit 7) 0 in every scan; without macro ch63 unchanged.
